vend_sequencer: RTL and testbench

// Top-level purchase controller for the vending machine. Owns the per-slot supply/price tables and the machine bank.

---
 rtl/vend_sequencer_if.sv | 48 ++++
 rtl/vend_sequencer.sv | 178 +++++++++++++++++
 tb/tb_vend_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vend_sequencer_if.sv
// Customer/admin bus of the vending purchase controller.
// Slave side is the sequencer; master side drives coins, requests and admin writes.
interface vend_sequencer_if #(
    parameter int NUM_SLOTS = 4,
    parameter int MONEY_W   = 4,
    parameter int SUPPLY_W  = 4,
    parameter int PRICE_W   = 4,
    parameter int QTY_W     = 4,
    parameter int BANK_W    = 11
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic                mode;
    logic                coin_valid;
    logic [MONEY_W-1:0]  coin_value;
    logic [SLOT_W-1:0]   sel_slot;
    logic [QTY_W-1:0]    qty;
    logic                buy_req;
    logic                cancel_req;
    logic                admin_we;
    logic [SLOT_W-1:0]   admin_slot;
    logic [SUPPLY_W-1:0] admin_supply;
    logic [PRICE_W-1:0]  admin_price;

    logic                busy;
    logic [MONEY_W-1:0]  credit;
    logic                coin_reject;
    logic                dispense_pulse;
    logic [SLOT_W-1:0]   dispense_slot;
    logic                change_valid;
    logic [MONEY_W-1:0]  change_amount;
    logic                redlight;
    logic [BANK_W-1:0]   bank_money;

    modport slave (
        input  mode, coin_valid, coin_value, sel_slot, qty, buy_req, cancel_req,
               admin_we, admin_slot, admin_supply, admin_price,
        output busy, credit, coin_reject, dispense_pulse, dispense_slot,
               change_valid, change_amount, redlight, bank_money
    );

    modport master (
        output mode, coin_valid, coin_value, sel_slot, qty, buy_req, cancel_req,
               admin_we, admin_slot, admin_supply, admin_price,
        input  busy, credit, coin_reject, dispense_pulse, dispense_slot,
               change_valid, change_amount, redlight, bank_money
    );
endinterface

// File: rtl/vend_sequencer.sv
// Vending purchase controller: collects coins, validates a purchase against the
// per-slot stock/price tables, dispenses one item per cycle and returns change.
module vend_sequencer #(
    parameter int NUM_SLOTS = 4,
    parameter int MONEY_W   = 4,
    parameter int SUPPLY_W  = 4,
    parameter int PRICE_W   = 4,
    parameter int QTY_W     = 4,
    parameter int BANK_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    vend_sequencer_if.slave   bus
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int COST_W = PRICE_W + QTY_W;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_CHECK, S_DISPENSE, S_CHANGE, S_ERROR
    } state_t;

    state_t              state_q;
    logic [SUPPLY_W-1:0] supply_q [NUM_SLOTS];
    logic [PRICE_W-1:0]  price_q  [NUM_SLOTS];
    logic [MONEY_W-1:0]  credit_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [QTY_W-1:0]    qty_q;
    logic [QTY_W-1:0]    remain_q;
    logic [COST_W-1:0]   cost_q;
    logic [BANK_W-1:0]   bank_q;

    logic                busy_q;
    logic                coin_reject_q;
    logic                dispense_q;
    logic [SLOT_W-1:0]   dispense_slot_q;
    logic                change_valid_q;
    logic [MONEY_W-1:0]  change_amount_q;
    logic                redlight_q;

    logic [MONEY_W:0]    coin_sum_d;
    logic                coin_fits_d;
    logic [MONEY_W-1:0]  credit_acc_d;
    logic [COST_W-1:0]   cost_d;
    logic [BANK_W:0]     bank_sum_d;
    logic [BANK_W-1:0]   bank_add_d;
    logic                check_fail_d;
    logic                late_coin_d;

    // The extra carry bit detects a coin that would overflow the credit register.
    assign coin_sum_d   = {1'b0, credit_q} + {1'b0, bus.coin_value};
    assign coin_fits_d  = ~coin_sum_d[MONEY_W];
    assign credit_acc_d = (bus.coin_valid && coin_fits_d) ? coin_sum_d[MONEY_W-1:0] : credit_q;

    assign cost_d       = COST_W'(price_q[slot_q]) * COST_W'(qty_q);
    assign bank_sum_d   = {1'b0, bank_q} + (BANK_W+1)'(cost_d);
    assign bank_add_d   = bank_sum_d[BANK_W] ? {BANK_W{1'b1}} : bank_sum_d[BANK_W-1:0];
    assign check_fail_d = (qty_q == '0)
                       || (32'(qty_q) > 32'(supply_q[slot_q]))
                       || (cost_d > COST_W'(credit_q));

    assign late_coin_d  = bus.coin_valid && (state_q != S_IDLE) && (state_q != S_COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                supply_q[i] <= '0;
                price_q[i]  <= '0;
            end
            credit_q        <= '0;
            slot_q          <= '0;
            qty_q           <= '0;
            remain_q        <= '0;
            cost_q          <= '0;
            bank_q          <= '0;
            busy_q          <= 1'b0;
            coin_reject_q   <= 1'b0;
            dispense_q      <= 1'b0;
            dispense_slot_q <= '0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            redlight_q      <= 1'b0;
        end else begin
            coin_reject_q  <= late_coin_d;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            redlight_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!bus.mode && bus.admin_we) begin
                        supply_q[bus.admin_slot] <= bus.admin_supply;
                        price_q[bus.admin_slot]  <= bus.admin_price;
                    end
                    if (bus.mode && bus.coin_valid) begin
                        credit_q <= bus.coin_value;
                        cost_q   <= '0;
                        state_q  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (bus.coin_valid && !coin_fits_d)
                        coin_reject_q <= 1'b1;
                    if (bus.cancel_req) begin
                        change_valid_q  <= 1'b1;
                        change_amount_q <= credit_acc_d;
                        credit_q        <= '0;
                        cost_q          <= '0;
                        busy_q          <= 1'b1;
                        state_q         <= S_CHANGE;
                    end else begin
                        credit_q <= credit_acc_d;
                        if (bus.buy_req) begin
                            slot_q  <= bus.sel_slot;
                            qty_q   <= bus.qty;
                            busy_q  <= 1'b1;
                            state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (check_fail_d) begin
                        cost_q     <= '0;
                        redlight_q <= 1'b1;
                        state_q    <= S_ERROR;
                    end else begin
                        // First item is released on the same edge that enters DISPENSE.
                        cost_q           <= cost_d;
                        bank_q           <= bank_add_d;
                        dispense_q       <= 1'b1;
                        dispense_slot_q  <= slot_q;
                        supply_q[slot_q] <= supply_q[slot_q] - 1'b1;
                        remain_q         <= qty_q - 1'b1;
                        state_q          <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    if (remain_q != '0) begin
                        dispense_q       <= 1'b1;
                        dispense_slot_q  <= slot_q;
                        supply_q[slot_q] <= supply_q[slot_q] - 1'b1;
                        remain_q         <= remain_q - 1'b1;
                    end else begin
                        change_valid_q  <= 1'b1;
                        change_amount_q <= credit_q - MONEY_W'(cost_q);
                        credit_q        <= '0;
                        state_q         <= S_CHANGE;
                    end
                end
                S_ERROR: begin
                    change_valid_q  <= 1'b1;
                    change_amount_q <= credit_q;
                    credit_q        <= '0;
                    state_q         <= S_CHANGE;
                end
                S_CHANGE: begin
                    cost_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.credit         = credit_q;
    assign bus.coin_reject    = coin_reject_q;
    assign bus.dispense_pulse = dispense_q;
    assign bus.dispense_slot  = dispense_slot_q;
    assign bus.change_valid   = change_valid_q;
    assign bus.change_amount  = change_amount_q;
    assign bus.redlight       = redlight_q;
    assign bus.bank_money     = bank_q;
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: table of admin writes and purchases, plus
// hand-written latency, late-coin and mid-dispense reset sequences.
module tb_vend_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vend_sequencer_if bus();
    vend_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_admin;
        bit         adm_mode;
        logic [1:0] slot;
        logic [3:0] sup;
        logic [3:0] price;
        logic [3:0] c0;
        logic [3:0] c1;
        bit         two;
        logic [3:0] q;
        bit         cancel;
        int         e_credit;
        int         e_rej;
        int         e_disp;
        int         e_red;
        int         e_change;
        int         e_bank;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.busy, bus.credit, bus.coin_reject, bus.dispense_pulse, bus.dispense_slot,
                    bus.change_valid, bus.change_amount, bus.redlight, bus.bank_money});
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int rej, disp, red, amt, first_i, last_i, chg_i;
        bit done;
        if (v.is_admin) begin
            bus.mode = v.adm_mode;
            bus.admin_we = 1'b1;
            bus.admin_slot = v.slot;
            bus.admin_supply = v.sup;
            bus.admin_price = v.price;
            @(negedge clk);
            bus.admin_we = 1'b0;
            chk("admin_bank", 32'(bus.bank_money), 32'(v.e_bank));
            chk("admin_busy", 32'(bus.busy), 32'd0);
            $display("txn %0d admin mode=%0d slot=%0d supply=%0d price=%0d bank=%0d",
                     idx, v.adm_mode, v.slot, v.sup, v.price, bus.bank_money);
            return;
        end
        rej = 0;
        bus.mode = 1'b1;
        bus.coin_valid = 1'b1;
        bus.coin_value = v.c0;
        @(negedge clk);
        rej += int'(bus.coin_reject);
        if (v.two) begin
            bus.coin_value = v.c1;
            @(negedge clk);
            rej += int'(bus.coin_reject);
        end
        bus.coin_valid = 1'b0;
        chk("credit", 32'(bus.credit), 32'(v.e_credit));
        chk("coin_reject_cnt", 32'(rej), 32'(v.e_rej));
        bus.sel_slot = v.slot;
        bus.qty = v.q;
        if (v.cancel) bus.cancel_req = 1'b1;
        else          bus.buy_req = 1'b1;
        done = 1'b0; disp = 0; red = 0; amt = 0; first_i = -1; last_i = -1; chg_i = -1;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            bus.buy_req = 1'b0;
            bus.cancel_req = 1'b0;
            if (bus.dispense_pulse) begin
                disp++;
                if (first_i < 0) first_i = c;
                last_i = c;
                chk("dispense_slot", 32'(bus.dispense_slot), 32'(v.slot));
            end
            if (bus.redlight) red++;
            if (bus.change_valid) begin
                done = 1'b1;
                amt = int'(bus.change_amount);
                chg_i = c;
            end
        end
        chk("change_seen", 32'(done), 32'd1);
        chk("dispense_cnt", 32'(disp), 32'(v.e_disp));
        chk("redlight_cnt", 32'(red), 32'(v.e_red));
        chk("change_amount", 32'(amt), 32'(v.e_change));
        if (v.e_disp > 0) begin
            chk("first_dispense_lat", 32'(first_i), 32'd1);
            chk("change_after_last", 32'(chg_i - last_i), 32'd1);
        end
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_credit", 32'(bus.credit), 32'd0);
        chk("bank", 32'(bus.bank_money), 32'(v.e_bank));
        $display("txn %0d buy slot=%0d qty=%0d cancel=%0d disp=%0d red=%0d change=%0d bank=%0d",
                 idx, v.slot, v.q, v.cancel, disp, red, amt, bus.bank_money);
    endtask

    vec_t vecs [15];
    vec_t extra;
    int   npulse;

    initial begin
        //            adm md sl sup pr  c0 c1 two q  can  cred rej disp red chg bank
        vecs[0]  = '{1, 0, 0, 5,  2,  0, 0, 0,  0, 0,   0,  0,  0,  0,  0,  0};
        vecs[1]  = '{1, 0, 1, 1,  3,  0, 0, 0,  0, 0,   0,  0,  0,  0,  0,  0};
        vecs[2]  = '{1, 0, 2, 15, 15, 0, 0, 0,  0, 0,   0,  0,  0,  0,  0,  0};
        vecs[3]  = '{1, 1, 3, 9,  1,  0, 0, 0,  0, 0,   0,  0,  0,  0,  0,  0};
        vecs[4]  = '{0, 0, 0, 0,  0,  8, 0, 0,  2, 0,   8,  0,  2,  0,  4,  4};
        vecs[5]  = '{0, 0, 0, 0,  0,  3, 0, 0,  2, 0,   3,  0,  0,  1,  3,  4};
        vecs[6]  = '{0, 0, 1, 0,  0,  8, 7, 1,  2, 0,  15,  0,  0,  1, 15,  4};
        vecs[7]  = '{0, 0, 0, 0,  0,  5, 0, 0,  0, 0,   5,  0,  0,  1,  5,  4};
        vecs[8]  = '{0, 0, 0, 0,  0,  9, 9, 1,  0, 1,   9,  1,  0,  0,  9,  4};
        vecs[9]  = '{0, 0, 0, 0,  0,  6, 0, 0,  3, 0,   6,  0,  3,  0,  0, 10};
        vecs[10] = '{0, 0, 0, 0,  0,  2, 0, 0,  1, 0,   2,  0,  0,  1,  2, 10};
        vecs[11] = '{0, 0, 1, 0,  0,  3, 0, 0,  1, 0,   3,  0,  1,  0,  0, 13};
        vecs[12] = '{0, 0, 2, 0,  0, 15, 0, 0,  2, 0,  15,  0,  0,  1, 15, 13};
        vecs[13] = '{0, 0, 2, 0,  0, 15, 0, 0,  1, 0,  15,  0,  1,  0,  0, 28};
        vecs[14] = '{0, 0, 3, 0,  0,  1, 0, 0,  1, 0,   1,  0,  0,  1,  1, 28};

        bus.mode = 1'b0; bus.coin_valid = 1'b0; bus.coin_value = '0;
        bus.sel_slot = '0; bus.qty = '0; bus.buy_req = 1'b0; bus.cancel_req = 1'b0;
        bus.admin_we = 1'b0; bus.admin_slot = '0; bus.admin_supply = '0; bus.admin_price = '0;

        #1;
        chk("reset_outputs", all_outs(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", all_outs(), 32'd0);

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // Latency, late coin and reset in the middle of a 3-item dispense.
        extra = '{1, 0, 3, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 28};
        run_vec(15, extra);
        bus.mode = 1'b1;
        bus.coin_valid = 1'b1;
        bus.coin_value = 4'd5;
        @(negedge clk);
        bus.coin_valid = 1'b0;
        bus.sel_slot = 2'd3;
        bus.qty = 4'd3;
        bus.buy_req = 1'b1;
        @(negedge clk);
        bus.buy_req = 1'b0;
        chk("check_no_pulse", 32'(bus.dispense_pulse), 32'd0);
        chk("check_busy", 32'(bus.busy), 32'd1);
        bus.coin_valid = 1'b1;
        bus.coin_value = 4'd1;
        @(negedge clk);
        bus.coin_valid = 1'b0;
        chk("buy_to_dispense_2", 32'(bus.dispense_pulse), 32'd1);
        chk("late_coin_reject", 32'(bus.coin_reject), 32'd1);
        chk("late_coin_credit", 32'(bus.credit), 32'd5);
        chk("bank_after_commit", 32'(bus.bank_money), 32'd31);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_dispense", all_outs(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            npulse += int'(bus.dispense_pulse) + int'(bus.change_valid);
        end
        chk("no_pulse_after_reset", 32'(npulse), 32'd0);
        chk("bank_cleared", 32'(bus.bank_money), 32'd0);
        $display("txn 16 reset mid-dispense pulses_after=%0d bank=%0d", npulse, bus.bank_money);

        // Tables were cleared, so slot 3 now has no stock.
        extra = '{0, 0, 3, 0, 0, 5, 0, 0, 1, 0, 5, 0, 0, 1, 5, 0};
        run_vec(17, extra);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
